// File: rtl/bcd_display_mux.sv
// bcd_display_mux: scans a packed BCD digit vector onto a multiplexed
// 7-segment display. The digit vector is captured once per frame, then each
// slot is lit for DIV cycles, the first of which is dark to stop ghosting
// between neighbouring digits. frame_tick pulses on the snapshot edge.
//
// Optional feature macro: BCD_DISPLAY_MUX_BLANK_ZEROS_EN
//   When defined, leading zero digits (any slot above 0 whose digit and all
//   higher digits are zero) are blanked. Slot 0 always shows its digit.
module bcd_display_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 12000
) (
    input  logic                      sys_clk,
    input  logic                      sys_reset,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_tick
);

    localparam int CNT_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]          r_cnt;
    logic [SLOT_W-1:0]         r_slot;
    logic [4*NUM_DIGITS-1:0]   r_snap;
    logic [6:0]                r_seg;
    logic [NUM_DIGITS-1:0]     r_digSel;
    logic                      r_frameTick;

    logic                      w_cntLast;
    logic                      w_frameEnd;
    logic [3:0]                w_curDigit;
    logic [NUM_DIGITS-1:0]     w_oneHot;
    logic                      w_blank;
    logic [6:0]                w_segNext;

    // BCD to 7-segment pattern (bit0=a .. bit6=g); non-BCD codes show a dash.
    function automatic logic [6:0] decodeBcd(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h40;
        endcase
        return pattern;
    endfunction

    assign w_cntLast  = (r_cnt == CNT_LAST);
    assign w_frameEnd = w_cntLast && (r_slot == SLOT_LAST);

    // Select the snapshot nibble and the one-hot enable for the current slot.
    always_comb begin
        w_curDigit = 4'd0;
        w_oneHot   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_slot == SLOT_W'(i)) begin
                w_curDigit  = r_snap[4*i +: 4];
                w_oneHot[i] = 1'b1;
            end
        end
    end

`ifdef BCD_DISPLAY_MUX_BLANK_ZEROS_EN
    logic w_zeroRun;

    // Walk from the top digit down; a slot is blank if it and every digit
    // above it are zero, except slot 0 which must always show something.
    always_comb begin
        w_zeroRun = 1'b1;
        w_blank   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zeroRun = w_zeroRun && (r_snap[4*i +: 4] == 4'd0);
            if ((r_slot == SLOT_W'(i)) && (i > 0)) begin
                w_blank = w_zeroRun;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    assign w_segNext = w_blank ? 7'h00 : decodeBcd(w_curDigit);

    // Cycle counter within a slot and slot pointer within a frame.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (w_cntLast) begin
            r_cnt <= '0;
            if (r_slot == SLOT_LAST) begin
                r_slot <= '0;
            end else begin
                r_slot <= r_slot + SLOT_W'(1);
            end
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Capture the digit vector only at the very end of a frame.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_snap <= '0;
        end else if (w_frameEnd) begin
            r_snap <= digits;
        end
    end

    // Registered display outputs, computed from the state before the edge.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_seg       <= 7'h00;
            r_digSel    <= '0;
            r_frameTick <= 1'b0;
        end else begin
            r_seg       <= w_segNext;
            r_digSel    <= (r_cnt == '0) ? '0 : w_oneHot;
            r_frameTick <= w_frameEnd;
        end
    end

    assign seg        = r_seg;
    assign dig_sel    = r_digSel;
    assign frame_tick = r_frameTick;

endmodule
